// File: rtl/csa_stream_accumulator_if.sv
`default_nettype none
// ============================================================================
//  Module      : csa_stream_accumulator_if
//  Description : Beat-in / result-out handshake bundle for the streaming
//                carry-save accumulator. The slave modport is the
//                accumulator side; the master modport is the producer and
//                consumer side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface csa_stream_accumulator_if #(
    parameter int W_IN  = 12,
    parameter int ACC_W = 15,
    parameter int LANES = 2,
    parameter int CNT_W = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [LANES*W_IN-1:0] in_data;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [ACC_W-1:0]      out_sum;
    logic                  out_ovf;
    logic [CNT_W-1:0]      out_beats;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_ovf, out_beats
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf, out_beats
    );
endinterface
`default_nettype wire

// File: rtl/csa_stream_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : csa_stream_accumulator
//  Description : Streaming multi-lane carry-save accumulator. Each accepted
//                beat's LANES operands are folded into a redundant sum/carry
//                pair through a chain of 3:2 compressors; the last beat
//                triggers one carry-propagate cycle and the resolved result
//                is offered under valid/ready.
//  Options     : CSA_ACC_SAT_EN - saturate out_sum to all-ones on overflow
//                (default: wrap mod 2^ACC_W). out_ovf is the same either way.
//  Revision    : 1.0 - initial release
// ============================================================================
module csa_stream_accumulator #(
    parameter int W_IN  = 12,
    parameter int ACC_W = 15,
    parameter int LANES = 2,
    parameter int CNT_W = 8
) (
    input  wire logic                clk,
    input  wire logic                rst,
    csa_stream_accumulator_if.slave  bus
);

    localparam logic [1:0] S_ACC = 2'd0;
    localparam logic [1:0] S_CPA = 2'd1;
    localparam logic [1:0] S_OUT = 2'd2;

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_beat;
    logic             w_release;

    logic [ACC_W-1:0] r_sum;
    logic [ACC_W-1:0] r_carry;
    logic             r_ovf;
    logic [CNT_W-1:0] r_cnt;

    logic [ACC_W-1:0] r_out_sum;
    logic             r_out_ovf;
    logic [CNT_W-1:0] r_out_beats;

    logic [ACC_W-1:0] w_s;
    logic [ACC_W-1:0] w_c;
    logic [ACC_W-1:0] w_x;
    logic [ACC_W-1:0] w_maj;
    logic             w_drop;

    logic [ACC_W:0]   w_cpa;
    logic             w_ovf_total;
    logic [ACC_W-1:0] w_result;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_ACC;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            S_ACC: begin
                w_in_ready = 1'b1;
                if (bus.in_valid && bus.in_last) begin
                    w_state_next = S_CPA;
                end
            end
            S_CPA: begin
                w_state_next = S_OUT;
            end
            S_OUT: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_next = S_ACC;
                end
            end
            default: begin
                w_state_next = S_ACC;
            end
        endcase
    end

    assign w_beat    = w_in_ready && bus.in_valid;
    assign w_release = w_out_valid && bus.out_ready;

    // Compressor chain: each lane is folded into the running pair with one
    // 3:2 stage. A majority bit at the MSB would be shifted out of the
    // carry word; since every operand is unsigned, losing it means the true
    // total no longer fits, so it is recorded as overflow.
    always_comb begin
        w_s    = r_sum;
        w_c    = r_carry;
        w_x    = '0;
        w_maj  = '0;
        w_drop = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            w_x    = ACC_W'(bus.in_data[k*W_IN +: W_IN]);
            w_maj  = (w_s & w_c) | (w_s & w_x) | (w_c & w_x);
            w_s    = w_s ^ w_c ^ w_x;
            w_drop = w_drop | w_maj[ACC_W-1];
            w_c    = {w_maj[ACC_W-2:0], 1'b0};
        end
    end

    // Carry-propagate add of the redundant pair; carry-out is also overflow.
    assign w_cpa       = {1'b0, r_sum} + {1'b0, r_carry};
    assign w_ovf_total = r_ovf | w_cpa[ACC_W];

`ifdef CSA_ACC_SAT_EN
    assign w_result = w_ovf_total ? {ACC_W{1'b1}} : w_cpa[ACC_W-1:0];
`else
    assign w_result = w_cpa[ACC_W-1:0];
`endif

    // Accumulator and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum       <= '0;
            r_carry     <= '0;
            r_ovf       <= 1'b0;
            r_cnt       <= '0;
            r_out_sum   <= '0;
            r_out_ovf   <= 1'b0;
            r_out_beats <= '0;
        end else begin
            if (w_beat) begin
                r_sum   <= w_s;
                r_carry <= w_c;
                r_ovf   <= r_ovf | w_drop;
                if (r_cnt != c_cnt_max) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
            if (r_state == S_CPA) begin
                r_out_sum   <= w_result;
                r_out_ovf   <= w_ovf_total;
                r_out_beats <= r_cnt;
            end
            // The next transaction must start from a clean pair.
            if (w_release) begin
                r_sum   <= '0;
                r_carry <= '0;
                r_ovf   <= 1'b0;
                r_cnt   <= '0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_sum   = r_out_sum;
    assign bus.out_ovf   = r_out_ovf;
    assign bus.out_beats = r_out_beats;

endmodule
`default_nettype wire

// File: tb/tb_csa_stream_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_csa_stream_accumulator
//  Description : Directed, table-driven bench for csa_stream_accumulator
//                plus hand-written bubble, back-pressure and reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_csa_stream_accumulator;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    csa_stream_accumulator_if #(.W_IN(12), .ACC_W(15), .LANES(2), .CNT_W(8)) bus ();

    csa_stream_accumulator #(.W_IN(12), .ACC_W(15), .LANES(2), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic [11:0] a;
        logic [11:0] b;
        logic [14:0] sum;
        logic        ovf;
        logic [7:0]  beats;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic send_beat(input logic [11:0] a, input logic [11:0] b, input logic last);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = {b, a};
        bus.in_last  = last;
        chk("in_ready_beat", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Called 1 time unit after the edge that accepted the last beat.
    task automatic wait_result(input string name, input logic [14:0] s,
                               input logic o, input logic [7:0] nb);
        int waited;
        chk({name, "_valid_t1"}, {31'd0, bus.out_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk({name, "_valid_t2"}, {31'd0, bus.out_valid}, 32'd1);
        waited = 0;
        while (!bus.out_valid && waited < 8) begin
            @(posedge clk);
            #1;
            waited++;
        end
        chk({name, "_sum"},   {17'd0, bus.out_sum},   {17'd0, s});
        chk({name, "_ovf"},   {31'd0, bus.out_ovf},   {31'd0, o});
        chk({name, "_beats"}, {24'd0, bus.out_beats}, {24'd0, nb});
        chk({name, "_inrdy"}, {31'd0, bus.in_ready},  32'd0);
    endtask

    task automatic release_result(input string name);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({name, "_released"}, {31'd0, bus.out_valid}, 32'd0);
    endtask

    task automatic run_txn(input int n, input logic [11:0] a, input logic [11:0] b);
        for (int i = 0; i < n; i++) begin
            send_beat(a, b, (i == n - 1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        vecs[0] = '{1,   12'd5,    12'd7,    15'd12,    1'b0, 8'd1};
        vecs[1] = '{3,   12'd4095, 12'd4095, 15'd24570, 1'b0, 8'd3};
`ifdef CSA_ACC_SAT_EN
        vecs[2] = '{5,   12'd4095, 12'd4095, 15'd32767, 1'b1, 8'd5};
`else
        vecs[2] = '{5,   12'd4095, 12'd4095, 15'd8182,  1'b1, 8'd5};
`endif
        vecs[3] = '{4,   12'd4095, 12'd4095, 15'd32760, 1'b0, 8'd4};
        vecs[4] = '{2,   12'd100,  12'd200,  15'd600,   1'b0, 8'd2};
        vecs[5] = '{1,   12'd0,    12'd0,    15'd0,     1'b0, 8'd1};
        vecs[6] = '{300, 12'd1,    12'd1,    15'd600,   1'b0, 8'd255};
        vecs[7] = '{1,   12'd4095, 12'd0,    15'd4095,  1'b0, 8'd1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_sum",   {17'd0, bus.out_sum},   32'd0);
        chk("rst_out_ovf",   {31'd0, bus.out_ovf},   32'd0);
        chk("rst_out_beats", {24'd0, bus.out_beats}, 32'd0);
        chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);

        for (int v = 0; v < 8; v++) begin
            run_txn(vecs[v].n, vecs[v].a, vecs[v].b);
            wait_result($sformatf("vec%0d", v), vecs[v].sum, vecs[v].ovf, vecs[v].beats);
            release_result($sformatf("vec%0d", v));
        end

        // Bubbles with junk data and a stray last must not disturb state.
        send_beat(12'd1, 12'd2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.in_data  = {12'd999, 12'd777};
            bus.in_last  = 1'b1;
        end
        send_beat(12'd3, 12'd4, 1'b1);
        wait_result("bubble", 15'd10, 1'b0, 8'd2);
        release_result("bubble");

        // Back-pressure: result must hold while beats are offered and refused.
        send_beat(12'd10, 12'd20, 1'b1);
        wait_result("hold", 15'd30, 1'b0, 8'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = {12'd7, 12'd7};
            bus.in_last  = 1'b1;
            @(posedge clk);
            #1;
            chk($sformatf("hold%0d_valid", i), {31'd0, bus.out_valid}, 32'd1);
            chk($sformatf("hold%0d_inrdy", i), {31'd0, bus.in_ready},  32'd0);
            chk($sformatf("hold%0d_sum", i),   {17'd0, bus.out_sum},   32'd30);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("hold_released", {31'd0, bus.out_valid}, 32'd0);
        send_beat(12'd1, 12'd1, 1'b1);
        wait_result("after_hold", 15'd2, 1'b0, 8'd1);
        release_result("after_hold");

        // Reset mid-transaction discards the partial sum.
        send_beat(12'd100, 12'd100, 1'b0);
        send_beat(12'd100, 12'd100, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("midrst_inrdy", {31'd0, bus.in_ready},  32'd1);
        chk("midrst_sum",   {17'd0, bus.out_sum},   32'd0);
        send_beat(12'd1, 12'd0, 1'b1);
        wait_result("midrst", 15'd1, 1'b0, 8'd1);
        release_result("midrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
